// File: rtl/reply_pkg.sv
// Shared definitions for the reply arbiter: state encoding, defaults, helpers.
package reply_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_PAD     = 2'd3
  } reply_state_e;

  localparam logic [7:0] DEF_PAD_BYTE = 8'h00;
  localparam int         DEF_TIMEOUT  = 255;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin requester selection: first requesting index at or after ptr,
// wrapping around. Purely combinational.
module rr_picker
  import reply_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int IDX_W = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any_req
);

  logic found_s;
  int   pos_s;

  // Scan upward from the pointer and lock onto the first active request.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found_s    = 1'b0;
    pos_s      = 0;
    for (int k = 0; k < N_SRC; k++) begin
      pos_s = int'(ptr) + k;
      if (pos_s >= N_SRC) begin
        pos_s = pos_s - N_SRC;
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && req[pos_s]) begin
        winner[pos_s] = 1'b1;
        winner_idx    = IDX_W'(pos_s);
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/reply_arbiter.sv
// Reply arbiter: grants one requester at a time and forwards its
// length-prefixed packet byte by byte into the shared host reply FIFO.
// A granted source that stops supplying bytes is aborted and the rest of its
// packet is filled with PAD_BYTE so the host framing stays intact.
module reply_arbiter
  import reply_pkg::*;
#(
  parameter int         N_SRC    = 4,
  parameter int         TIMEOUT  = DEF_TIMEOUT,
  parameter logic [7:0] PAD_BYTE = DEF_PAD_BYTE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]   src_ack,
  output logic [7:0]         out_data,
  output logic               out_wr,
  input  logic               out_full,
  output logic [N_SRC-1:0]   grant,
  output logic               busy,
  output logic               err_timeout
);

  localparam int               IDX_W    = idx_width(N_SRC);
  localparam int               STV_W    = $clog2(TIMEOUT + 1);
  // The abort fires on the edge that would bring the count up to TIMEOUT.
  localparam logic [STV_W-1:0] STV_LAST = STV_W'(TIMEOUT - 1);

  reply_state_e     state_r,       state_nxt_s;
  logic [N_SRC-1:0] grant_r,       grant_nxt_s;
  logic [IDX_W-1:0] win_idx_r,     win_nxt_s;
  logic [IDX_W-1:0] ptr_r,         ptr_nxt_s;
  logic [7:0]       remaining_r,   rem_nxt_s;
  logic [STV_W-1:0] starve_r,      starve_nxt_s;
  logic             err_timeout_r, err_nxt_s;

  logic             out_wr_s;
  logic [7:0]       out_data_s;
  logic [N_SRC-1:0] src_ack_s;
  logic             cur_valid_s;
  logic [7:0]       src_bytes_s [N_SRC];

  logic [N_SRC-1:0] pick_onehot_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;

  // Pointer that follows the source just served, wrapping at N_SRC.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_SRC - 1)) begin
      return '0;
    end else begin
      return idx + 1'b1;
    end
  endfunction

  rr_picker #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (src_req),
    .ptr        (ptr_r),
    .winner     (pick_onehot_s),
    .winner_idx (pick_idx_s),
    .any_req    (pick_any_s)
  );

  // Split the flat data bus into per-source byte lanes.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_bytes_s[i] = src_data[8*i +: 8];
    end
  end

  assign cur_valid_s = src_valid[win_idx_r];

  // Next-state, counters and the same-cycle FIFO write / source ack.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = grant_r;
    win_nxt_s    = win_idx_r;
    ptr_nxt_s    = ptr_r;
    rem_nxt_s    = remaining_r;
    starve_nxt_s = starve_r;
    err_nxt_s    = 1'b0;
    out_wr_s     = 1'b0;
    out_data_s   = 8'h00;
    src_ack_s    = '0;

    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_nxt_s  = pick_onehot_s;
          win_nxt_s    = pick_idx_s;
          starve_nxt_s = '0;
          state_nxt_s  = ST_HEADER;
        end else begin
          grant_nxt_s  = '0;
        end
      end

      ST_HEADER, ST_PAYLOAD: begin
        out_data_s = src_bytes_s[win_idx_r];
        if (cur_valid_s && !out_full) begin
          out_wr_s     = 1'b1;
          src_ack_s    = grant_r;
          starve_nxt_s = '0;
          if (state_r == ST_HEADER) begin
            rem_nxt_s = out_data_s;
            if (out_data_s == 8'h00) begin
              grant_nxt_s = '0;
              ptr_nxt_s   = wrap_inc(win_idx_r);
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_PAYLOAD;
            end
          end else begin
            rem_nxt_s = remaining_r - 8'd1;
            if (remaining_r == 8'd1) begin
              grant_nxt_s = '0;
              ptr_nxt_s   = wrap_inc(win_idx_r);
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_PAYLOAD;
            end
          end
        end else if (!cur_valid_s && !out_full) begin
          if (starve_r == STV_LAST) begin
            state_nxt_s  = ST_PAD;
            err_nxt_s    = 1'b1;
            starve_nxt_s = '0;
            // An abort before the header still owes the host a 1-byte packet.
            if (state_r == ST_HEADER) begin
              rem_nxt_s = 8'd1;
            end else begin
              rem_nxt_s = remaining_r;
            end
          end else begin
            starve_nxt_s = starve_r + 1'b1;
          end
        end else begin
          // FIFO full: nothing moves and the starve count is frozen.
          starve_nxt_s = starve_r;
        end
      end

      ST_PAD: begin
        out_data_s = PAD_BYTE;
        if (!out_full) begin
          out_wr_s  = 1'b1;
          rem_nxt_s = remaining_r - 8'd1;
          if (remaining_r == 8'd1) begin
            grant_nxt_s = '0;
            ptr_nxt_s   = wrap_inc(win_idx_r);
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PAD;
          end
        end else begin
          rem_nxt_s = remaining_r;
        end
      end

      default: begin
        grant_nxt_s = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset drops any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      grant_r       <= '0;
      win_idx_r     <= '0;
      ptr_r         <= '0;
      remaining_r   <= 8'h00;
      starve_r      <= '0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      grant_r       <= grant_nxt_s;
      win_idx_r     <= win_nxt_s;
      ptr_r         <= ptr_nxt_s;
      remaining_r   <= rem_nxt_s;
      starve_r      <= starve_nxt_s;
      err_timeout_r <= err_nxt_s;
    end
  end

  assign src_ack     = src_ack_s;
  assign out_wr      = out_wr_s;
  assign out_data    = out_data_s;
  assign grant       = grant_r;
  assign busy        = (state_r != ST_IDLE);
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_reply_arbiter.sv
// Directed bench for reply_arbiter (N_SRC=4, TIMEOUT=8, PAD_BYTE=00).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_reply_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_req;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_ack;
  logic [7:0]  out_data;
  logic        out_wr;
  logic        out_full;
  logic [3:0]  grant;
  logic        busy;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reply_arbiter #(
    .N_SRC    (4),
    .TIMEOUT  (8),
    .PAD_BYTE (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_req     (src_req),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ack     (src_ack),
    .out_data    (out_data),
    .out_wr      (out_wr),
    .out_full    (out_full),
    .grant       (grant),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs after the falling edge, then let them settle.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] vld,
                     input logic [31:0] data, input logic full);
    @(negedge clk);
    reset     = rst;
    src_req   = req;
    src_valid = vld;
    src_data  = data;
    out_full  = full;
    #1;
  endtask

  task automatic ex(input string tag, input logic wr, input logic [7:0] d,
                    input logic [3:0] ack, input logic [3:0] g,
                    input logic bz, input logic er);
    chk({tag, "/out_wr"}, 32'(out_wr), 32'(wr));
    if (wr) chk({tag, "/out_data"}, 32'(out_data), 32'(d));
    chk({tag, "/src_ack"}, 32'(src_ack), 32'(ack));
    chk({tag, "/grant"}, 32'(grant), 32'(g));
    chk({tag, "/busy"}, 32'(busy), 32'(bz));
    chk({tag, "/err_timeout"}, 32'(err_timeout), 32'(er));
  endtask

  initial begin
    reset = 1'b1; src_req = 4'b0000; src_valid = 4'b0000;
    src_data = 32'h0000_0000; out_full = 1'b0;

    // Reset holds everything idle even with activity on the inputs.
    cyc(1'b1, 4'b0001, 4'b0001, 32'h0000_0003, 1'b0); ex("reset0", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 4'b0001, 32'h0000_0003, 1'b0); ex("reset1", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Single packet from src0: 03 AA BB CC.
    cyc(1'b0, 4'b0001, 4'b0000, 32'h0000_0000, 1'b0); ex("s1_idle", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 4'b0001, 4'b0001, 32'h0000_0003, 1'b0); ex("s1_hdr",  1'b1, 8'h03, 4'b0001, 4'b0001, 1'b1, 1'b0);
    cyc(1'b0, 4'b0001, 4'b0001, 32'h0000_00AA, 1'b0); ex("s1_p0",   1'b1, 8'hAA, 4'b0001, 4'b0001, 1'b1, 1'b0);
    cyc(1'b0, 4'b0001, 4'b0001, 32'h0000_00BB, 1'b0); ex("s1_p1",   1'b1, 8'hBB, 4'b0001, 4'b0001, 1'b1, 1'b0);
    cyc(1'b0, 4'b0001, 4'b0001, 32'h0000_00CC, 1'b0); ex("s1_p2",   1'b1, 8'hCC, 4'b0001, 4'b0001, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0); ex("s1_done", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Pointer is now 1: src0 and src1 both request, src1 must win.
    cyc(1'b0, 4'b0011, 4'b0000, 32'h0000_0000, 1'b0); ex("ptr_idle", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 4'b0011, 4'b0010, 32'h0000_0000, 1'b0); ex("ptr_src1", 1'b1, 8'h00, 4'b0010, 4'b0010, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0); ex("ptr_done", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Backpressure on src2 packet 02 11 22: five full cycles mid-payload.
    cyc(1'b0, 4'b0100, 4'b0000, 32'h0000_0000, 1'b0); ex("bp_idle", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 4'b0100, 4'b0100, 32'h0002_0000, 1'b0); ex("bp_hdr",  1'b1, 8'h02, 4'b0100, 4'b0100, 1'b1, 1'b0);
    cyc(1'b0, 4'b0100, 4'b0100, 32'h0011_0000, 1'b0); ex("bp_p0",   1'b1, 8'h11, 4'b0100, 4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'b0100, 4'b0100, 32'h0022_0000, 1'b1); ex("bp_stall", 1'b0, 8'h00, 4'b0000, 4'b0100, 1'b1, 1'b0);
    end
    cyc(1'b0, 4'b0100, 4'b0100, 32'h0022_0000, 1'b0); ex("bp_p1",   1'b1, 8'h22, 4'b0100, 4'b0100, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0); ex("bp_done", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Fairness: pointer is 3, src0 and src2 send 1-byte packets -> 0,2,0,2.
    cyc(1'b0, 4'b0101, 4'b0101, 32'h0000_0000, 1'b0); ex("fair_idle", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] g;
      g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      cyc(1'b0, 4'b0101, 4'b0101, 32'h0000_0000, 1'b0); ex("fair_grant", 1'b1, 8'h00, g, g, 1'b1, 1'b0);
      cyc(1'b0, (k == 3) ? 4'b0000 : 4'b0101, 4'b0101, 32'h0000_0000, 1'b0);
      ex("fair_gap", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    end

    // Header abort: src3 granted, never valid; non-granted src1 valid is ignored.
    cyc(1'b0, 4'b1010, 4'b0000, 32'h0000_0000, 1'b0); ex("ha_idle", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'b1010, 4'b0010, 32'h0000_5500, 1'b0); ex("ha_starve", 1'b0, 8'h00, 4'b0000, 4'b1000, 1'b1, 1'b0);
    end
    cyc(1'b0, 4'b1010, 4'b0010, 32'h0000_5500, 1'b0); ex("ha_pad",  1'b1, 8'h00, 4'b0000, 4'b1000, 1'b1, 1'b1);
    cyc(1'b0, 4'b0010, 4'b0000, 32'h0000_0000, 1'b0); ex("ha_next", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Timeout mid-payload: src1 sends 04 01 then stalls; three pad bytes follow.
    cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_0400, 1'b0); ex("to_hdr", 1'b1, 8'h04, 4'b0010, 4'b0010, 1'b1, 1'b0);
    cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_0100, 1'b0); ex("to_p0",  1'b1, 8'h01, 4'b0010, 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'b0010, 4'b0000, 32'h0000_0000, 1'b0); ex("to_starve", 1'b0, 8'h00, 4'b0000, 4'b0010, 1'b1, 1'b0);
    end
    cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_7700, 1'b0); ex("to_pad0",    1'b1, 8'h00, 4'b0000, 4'b0010, 1'b1, 1'b1);
    cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_7700, 1'b1); ex("to_padfull", 1'b0, 8'h00, 4'b0000, 4'b0010, 1'b1, 1'b0);
    cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_7700, 1'b0); ex("to_pad1",    1'b1, 8'h00, 4'b0000, 4'b0010, 1'b1, 1'b0);
    cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_7700, 1'b0); ex("to_pad2",    1'b1, 8'h00, 4'b0000, 4'b0010, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0); ex("to_done",    1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Reset mid-payload of a src3 packet; afterwards arbitration restarts at 0.
    cyc(1'b0, 4'b1000, 4'b0000, 32'h0000_0000, 1'b0); ex("rm_idle",  1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 4'b1000, 4'b1000, 32'h0500_0000, 1'b0); ex("rm_hdr",   1'b1, 8'h05, 4'b1000, 4'b1000, 1'b1, 1'b0);
    cyc(1'b0, 4'b1000, 4'b1000, 32'h0600_0000, 1'b0); ex("rm_p0",    1'b1, 8'h06, 4'b1000, 4'b1000, 1'b1, 1'b0);
    cyc(1'b1, 4'b1000, 4'b1000, 32'h0700_0000, 1'b0); ex("rm_reset", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 4'b1001, 4'b0000, 32'h0000_0000, 1'b0); ex("rm_after", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 4'b1001, 4'b0001, 32'h0000_0000, 1'b0); ex("rm_fresh", 1'b1, 8'h00, 4'b0001, 4'b0001, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0); ex("rm_done",  1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reply_arbiter.md
REPLY_ARBITER -- requirements
Module: reply_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, number of reply requesters.
REQ-002 Parameter TIMEOUT, default 255, consecutive granted-source starve cycles before abort.
REQ-003 Parameter PAD_BYTE, default 8'h00, filler byte written on abort.
REQ-004 clk  in  1  single block clock; all logic on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 src_req  in  N_SRC  per-source packet request; held high until its packet completes.
REQ-007 src_valid  in  N_SRC  per-source byte-valid.
REQ-008 src_data  in  8*N_SRC  per-source byte; source i occupies bits [8i+7:8i].
REQ-009 src_ack  out  N_SRC  byte accepted from source i this cycle.
REQ-010 out_data  out  8  byte to the shared host reply FIFO.
REQ-011 out_wr  out  1  write strobe to the reply FIFO.
REQ-012 out_full  in  1  reply FIFO full; no write is issued while high.
REQ-013 grant  out  N_SRC  one-hot registered grant, all-zero when idle.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 err_timeout  out  1  one-cycle pulse when a packet is aborted.

Function
REQ-016 Packet framing: first byte = length L (0..255), followed by L payload bytes; total L+1 bytes.
REQ-017 States: IDLE, HEADER, PAYLOAD, PAD.
REQ-018 IDLE: if any src_req is high, the round-robin winner (first requesting index at or after pointer, wrapping) is granted at the next edge and the state goes to HEADER; otherwise the state remains IDLE.
REQ-019 Transfer condition in HEADER/PAYLOAD: src_valid[g] & ~out_full; out_wr and src_ack[g] assert combinationally in that same cycle; out_data = src_data[g].
REQ-020 HEADER: on transfer, remaining count <= byte value; next state is PAYLOAD, or release if the value is 0.
REQ-021 PAYLOAD: each transfer decrements remaining; the transfer with remaining == 1 causes release.
REQ-022 Release: at the edge completing the packet, grant <= 0, state <= IDLE, pointer <= (winner+1) mod N_SRC.
REQ-023 Re-arbitration requires one IDLE cycle between packets; there is no back-to-back grant.
REQ-024 src_req deassertion mid-packet is ignored; the grant is held until the count completes or aborts.
REQ-025 Starve counter counts cycles in HEADER/PAYLOAD with src_valid[g] low; it resets on every transfer and is not incremented while out_full is high.
REQ-026 When the starve counter reaches TIMEOUT, the next state is PAD and err_timeout pulses for one cycle.
REQ-027 PAD: writes PAD_BYTE whenever ~out_full until the packet completes; if aborted in HEADER, one PAD_BYTE is written as header (L=0); src_ack stays low; then release as in REQ-022.
REQ-028 src_ack is never asserted to a non-granted source; out_wr is never asserted while out_full is high.
REQ-029 src_valid from non-granted sources is ignored.

Reset
REQ-030 While reset is high the block is held in IDLE with grant=0, pointer=0, remaining=0, starve counter=0, err_timeout=0, out_wr=0, src_ack=0, busy=0.
REQ-031 Reset mid-packet drops the packet with no pad bytes; framing recovery is the host's responsibility.

Structure
REQ-032 A shared package reply_pkg holds the state encoding enumeration, the default PAD_BYTE, and the default TIMEOUT.
REQ-033 The round-robin selection is one sub-module, rr_picker (inputs: request vector and pointer; outputs: one-hot winner and index).
REQ-034 All remaining logic is in reply_arbiter.

Verification
REQ-035 Single packet: src0 sends 03,AA,BB,CC with out_full=0 -> four out_wr cycles carrying 03,AA,BB,CC; grant=0001 during the packet; idle afterwards; pointer=1.
REQ-036 Fairness: src0 and src2 request continuously with 1-byte packets (00) -> grant order 0,2,0,2; each grant is followed by one IDLE cycle.
REQ-037 Backpressure: out_full held high for 5 cycles in mid-payload of 02,11,22 -> no writes and no acks during the stall; no timeout; the bytes complete after the stall.
REQ-038 Timeout: TIMEOUT=8, src1 sends 04,01 then drops valid -> after 8 starve cycles err_timeout pulses; three 00 bytes are written; the grant is released.
REQ-039 Header abort: src3 granted and never valid, TIMEOUT=8 -> a single 00 is written; err_timeout pulses; the next requester is granted.
REQ-040 Reset mid-PAYLOAD -> the next cycle shows grant=0, busy=0, out_wr=0; a fresh request is served from pointer 0.
